// File: rtl/dcache_snoop.sv
// Snoop responder for one core's 2-way L1 dcache: looks up a snooped block,
// supplies dirty data one word per handshake, then downgrades/invalidates it.
module dcache_snoop #(
  parameter int NSETS = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ccwait,
  input  logic                       ccinv,
  input  logic [31:0]                ccsnoopaddr,
  input  logic                       dwait,
  input  logic                       cache_idle,
  input  logic [1:0]                 fr_valid,
  input  logic [1:0]                 fr_dirty,
  input  logic [51:0]                fr_tag,
  input  logic [127:0]               fr_data,
  input  logic                       link_valid,
  input  logic [31:0]                link_addr,
  output logic [$clog2(NSETS)-1:0]   fr_idx,
  output logic                       upd_en,
  output logic                       upd_way,
  output logic                       upd_valid,
  output logic                       upd_dirty,
  output logic                       ccwrite,
  output logic [31:0]                dstore,
  output logic                       snoop_busy,
  output logic                       link_clear
);

  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 29 - IDXW;

  typedef enum logic [2:0] {IDLE, LOOKUP, XFER0, XFER1, UPDATE} state_t;

  state_t      state_r, state_s;
  logic [31:3] saddr_r;
  logic        sinv_r;
  logic        hway_r;
  logic [31:0] w0_r, w1_r;

  logic        hit0_s, hit1_s, hit_s, hway_s, hdirty_s;
  logic [31:0] hw0_s, hw1_s;
  logic        capture_s;
  logic        unused_s;

  // Byte offset bits never matter: blocks are two aligned words.
  assign unused_s  = ^{ccsnoopaddr[2:0], link_addr[2:0]};
  assign capture_s = (state_r == IDLE) && ccwait && cache_idle;

  // Tag compare on the frame read port; way0 takes priority on a double hit.
  always_comb begin
    hit0_s   = fr_valid[0] && (fr_tag[TAGW-1:0] == saddr_r[31:3+IDXW]);
    hit1_s   = fr_valid[1] && (fr_tag[2*TAGW-1:TAGW] == saddr_r[31:3+IDXW]);
    hit_s    = hit0_s || hit1_s;
    hway_s   = !hit0_s;
    hdirty_s = hit0_s ? fr_dirty[0] : fr_dirty[1];
    hw0_s    = hit0_s ? fr_data[31:0]  : fr_data[95:64];
    hw1_s    = hit0_s ? fr_data[63:32] : fr_data[127:96];
  end

  // Next-state logic; a dropped ccwait aborts any in-flight snoop.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) state_s = LOOKUP;
        else           state_s = IDLE;
      end
      LOOKUP: begin
        if (!ccwait || !hit_s) state_s = IDLE;
        else if (hdirty_s)     state_s = XFER0;
        else                   state_s = UPDATE;
      end
      XFER0: begin
        if (!ccwait)     state_s = IDLE;
        else if (!dwait) state_s = XFER1;
        else             state_s = XFER0;
      end
      XFER1: begin
        if (!ccwait)     state_s = IDLE;
        else if (!dwait) state_s = UPDATE;
        else             state_s = XFER1;
      end
      UPDATE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus snoop request and hit-data latches.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      saddr_r <= 29'd0;
      sinv_r  <= 1'b0;
      hway_r  <= 1'b0;
      w0_r    <= 32'd0;
      w1_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        saddr_r <= ccsnoopaddr[31:3];
        sinv_r  <= ccinv;
      end
      if (state_r == LOOKUP) begin
        hway_r <= hway_s;
        w0_r   <= hw0_s;
        w1_r   <= hw1_s;
      end
    end
  end

  // Output decode from the registered state and latches.
  always_comb begin
    fr_idx     = saddr_r[3 +: IDXW];
    upd_en     = 1'b0;
    upd_way    = 1'b0;
    upd_valid  = 1'b0;
    upd_dirty  = 1'b0;
    ccwrite    = 1'b0;
    dstore     = 32'd0;
    link_clear = 1'b0;
    snoop_busy = (state_r != IDLE) || ccwait;
    case (state_r)
      XFER0: begin
        ccwrite = 1'b1;
        dstore  = w0_r;
      end
      XFER1: begin
        ccwrite = 1'b1;
        dstore  = w1_r;
      end
      UPDATE: begin
        upd_en     = 1'b1;
        upd_way    = hway_r;
        upd_valid  = !sinv_r;
        link_clear = sinv_r && link_valid && (link_addr[31:3] == saddr_r);
      end
      default: begin
        ccwrite = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/dcache_snoop.md
# dcache_snoop

Cache-side snoop responder for one core's L1 data cache (2-way, 8 sets, 2-word blocks), answering the bus coherence controller. It captures snoop requests (`ccwait`, `ccinv`, `ccsnoopaddr`), looks up the frame arrays, and supplies dirty blocks cache-to-cache one word per handshake. It then applies the MSI state change (M->S on read snoop, ->I on invalidate) and clears a matching LL/SC link. One instance sits beside each core's dcache miss FSM.

## Interface
- `NSETS`, 8: sets; index = `addr[5:3]`, tag = `addr[31:6]`, block offset = `addr[2]`.
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `ccwait` in 1: controller snooping this cache.
- `ccinv` in 1: snoop requires invalidation (BusRdX / upgrade).
- `ccsnoopaddr` in 32: snooped byte address.
- `dwait` in 1: low = controller accepted current `dstore` word.
- `cache_idle` in 1: miss FSM idle or parked; lookup may start.
- `fr_valid`, `fr_dirty` in 2: per-way state at `fr_idx`.
- `fr_tag` in 52: {way1 tag, way0 tag}.
- `fr_data` in 128: {w1 word1, w1 word0, w0 word1, w0 word0}.
- `link_valid` in 1, `link_addr` in 32: LL reservation.
- `fr_idx` out 3: set being read.
- `upd_en` out 1, `upd_way` out 1, `upd_valid` out 1, `upd_dirty` out 1: one-cycle frame state write.
- `ccwrite` out 1: hit on dirty line; supplying data.
- `dstore` out 32: word being supplied.
- `snoop_busy` out 1: miss FSM must not start a transaction.
- `link_clear` out 1: one-cycle pulse clearing the reservation.

## Operation
- States: IDLE, LOOKUP, XFER0, XFER1, UPDATE.
- IDLE:
  - `ccwait && cache_idle` -> latch `ccsnoopaddr` into `saddr` and `ccinv` into `sinv` -> LOOKUP.
  - `ccwait && !cache_idle` -> stay IDLE with `snoop_busy`=1.
- LOOKUP:
  - `fr_idx = saddr[5:3]`; hit per way = valid && tag == `saddr[31:6]`; latch `hway`, `hdirty`, and the hit way's two words.
  - Both ways hit is illegal; way0 wins.
  - Miss -> IDLE.
  - Hit && dirty -> XFER0.
  - Hit && clean -> UPDATE.
- XFER0: `ccwrite`=1, `dstore` = word0; `!dwait` -> XFER1.
- XFER1: `ccwrite`=1, `dstore` = word1; `!dwait` -> UPDATE.
- UPDATE: `upd_en`=1 for one cycle, `upd_way` = `hway`, then -> IDLE.
  - `sinv`=1: `upd_valid`=0, `upd_dirty`=0.
  - `sinv`=0: `upd_valid`=1, `upd_dirty`=0 (M->S, or S->S).
- `link_clear` pulses in UPDATE when `sinv && link_valid && link_addr[31:3] == saddr[31:3]`.
- `snoop_busy`=1 in every non-IDLE state and in IDLE while `ccwait`=1.
- Abort: `ccwait` dropping in LOOKUP/XFER0/XFER1 -> IDLE. No update and no `link_clear` on abort. The line remains in its previous state.
- `ccinv` changing after capture is ignored; `sinv` is used.

## Timing
- Reset: state IDLE, all outputs 0, `fr_idx`=0, latches cleared.
- Reset mid-transfer returns to IDLE immediately (async); no update is issued.
- Clean-hit path: `ccwait` at edge 0 -> LOOKUP in cycle 1, UPDATE in cycle 2, IDLE in cycle 3.
- Dirty-hit path: XFER0 from cycle 2.
  - Each word holds until the edge where `dwait`=0.
  - With `dwait`=0 throughout: XFER0 cycle 2, XFER1 cycle 3, UPDATE cycle 4.
- Miss path: LOOKUP in cycle 1, IDLE in cycle 2, no outputs beyond `snoop_busy`.
- `ccwrite` and `dstore` are registered-state decodes, stable for the whole state; `dstore`=0 outside XFER states.
- Back-to-back snoops: a new capture may occur in the IDLE cycle immediately after UPDATE.
- `cache_idle` is sampled only in IDLE; once a snoop starts, the snoop owns the frame read port until IDLE.

## Test plan
- Read snoop of dirty line: way1 set 2 tag 0x1, data {0xDEADBEEF, 0xCAFEF00D}; `ccsnoopaddr`=0x00000050, `ccinv`=0, `dwait`=0 -> XFER0 `dstore`=0xCAFEF00D, XFER1 `dstore`=0xDEADBEEF, UPDATE way1 valid=1 dirty=0, total 4 cycles.
- Invalidate snoop of clean line with matching link: `link_addr`=0x00000054, snoop 0x00000050, `ccinv`=1 -> no `ccwrite`; UPDATE `upd_valid`=0; `link_clear` pulses once.
- Snoop miss: tag mismatch on both ways -> no `upd_en`, no `ccwrite`; IDLE after 2 cycles.
- `dwait` stall: `dwait`=1 for 3 cycles in XFER0 -> word0 held 4 cycles, then word1.
- Abort: `ccwait` drops in XFER1 -> IDLE next cycle with no `upd_en`; `nRST` pulse in XFER0 -> all outputs 0 at once.
- Contention: `ccwait`=1 while `cache_idle`=0 for 5 cycles -> `snoop_busy`=1 throughout, LOOKUP the cycle after `cache_idle` rises.
